// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Main control FSM of the RV32I multicycle core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int XLEN = 32
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o,
    output logic       trap_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        c_FETCH    = 4'd0,
        c_DECODE   = 4'd1,
        c_MEMADR   = 4'd2,
        c_MEMREAD  = 4'd3,
        c_MEMWB    = 4'd4,
        c_MEMWRITE = 4'd5,
        c_EXECR    = 4'd6,
        c_EXECI    = 4'd7,
        c_ALUWB    = 4'd8,
        c_BRANCH   = 4'd9,
        c_JAL      = 4'd10,
        c_JALR     = 4'd11,
        c_JALR2    = 4'd12,
        c_LUI      = 4'd13,
        c_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    // The controller is width-agnostic; XLEN only documents the datapath it drives.
    generate
        if (XLEN < 32) begin : g_xlen_narrow
        end
    endgenerate

    // funct7b5 is consumed by the ALU decoder, not by the sequencing FSM.
    logic w_unused_funct7b5;
    assign w_unused_funct7b5 = funct7b5_i;

    state_t r_state;
    state_t w_next_state;
    logic   r_trap;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= c_FETCH;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_trap  <= r_trap | (w_next_state == c_TRAP);
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        imm_src_o    = 3'b000;

        case (r_state)
            c_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                if (mem_ready_i) begin
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                // Branch target is precomputed into ALUOut while decoding.
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = 3'b010;
                case (opcode_i)
                    c_OP_LOAD, c_OP_STORE: w_next_state = c_MEMADR;
                    c_OP_R:                w_next_state = c_EXECR;
                    c_OP_I:                w_next_state = c_EXECI;
                    c_OP_BRANCH:           w_next_state = c_BRANCH;
                    c_OP_JAL:              w_next_state = c_JAL;
                    c_OP_JALR:             w_next_state = c_JALR;
                    c_OP_LUI:              w_next_state = c_LUI;
                    default:               w_next_state = c_TRAP;
                endcase
            end
            c_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                if (opcode_i == c_OP_LOAD) begin
                    imm_src_o    = 3'b000;
                    w_next_state = c_MEMREAD;
                end else begin
                    imm_src_o    = 3'b001;
                    w_next_state = c_MEMWRITE;
                end
            end
            c_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    w_next_state = c_MEMWB;
                end
            end
            c_MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                w_next_state = c_FETCH;
            end
            c_MEMWRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    w_next_state = c_FETCH;
                end
            end
            c_EXECR: begin
                alu_src_a_o  = 2'b10;
                alu_op_o     = 2'b10;
                w_next_state = c_ALUWB;
            end
            c_EXECI: begin
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                alu_op_o     = 2'b10;
                w_next_state = c_ALUWB;
            end
            c_ALUWB: begin
                reg_write_o  = 1'b1;
                w_next_state = c_FETCH;
            end
            c_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                case (funct3_i)
                    3'b000: begin
                        pc_write_o   = zero_i;
                        w_next_state = c_FETCH;
                    end
                    3'b001: begin
                        pc_write_o   = ~zero_i;
                        w_next_state = c_FETCH;
                    end
                    default: w_next_state = c_TRAP;
                endcase
            end
            c_JAL: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                pc_write_o   = 1'b1;
                w_next_state = c_ALUWB;
            end
            c_JALR: begin
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                w_next_state = c_JALR2;
            end
            c_JALR2: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                pc_write_o   = 1'b1;
                w_next_state = c_ALUWB;
            end
            c_LUI: begin
                // rs1 is forced to x0 by the datapath, so rs1 + imm yields the U-immediate.
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                imm_src_o    = 3'b100;
                w_next_state = c_ALUWB;
            end
            c_TRAP: begin
                w_next_state = c_TRAP;
            end
            default: begin
                w_next_state = c_TRAP;
            end
        endcase
    end

    assign trap_o  = r_trap;
    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Randomized self-checking bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
                           ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                           ST_EXECR = 4'd6,  ST_EXECI = 4'd7,  ST_ALUWB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JAL = 4'd10,   ST_JALR = 4'd11,
                           ST_JALR2 = 4'd12, ST_LUI = 4'd13,   ST_TRAP = 4'd14;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_BNE = 6, K_JAL = 7, K_JALR = 8, K_BADBR = 9, K_ILL = 10;

    typedef struct packed {
        logic       req, we, adr, irw, pcw, rw;
        logic [1:0] a, b, op, res;
        logic [2:0] imm;
        logic       trap;
    } outs_t;

    typedef struct packed {
        logic       rdy, z;
        logic [3:0] st;
        outs_t      o;
    } step_t;

    logic       clk_i = 1'b0;
    logic       rstn_i, zero_i, mem_ready_i, funct7b5_i;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o, trap_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [2:0] imm_src_o;
    logic [3:0] state_o;

    int    n_checks = 0;
    int    n_errors = 0;
    int    idle_mode;
    step_t q_steps[$];

    multicycle_controller #(.XLEN(32)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .funct7b5_i(funct7b5_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .result_src_o(result_src_o), .imm_src_o(imm_src_o), .trap_o(trap_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic outs_t observed();
        return {mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
                alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o, trap_o};
    endfunction

    // Idle-state ready value: random unless a directed test pins it to 1.
    function automatic logic idle_rdy();
        return (idle_mode == 2) ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy, input logic z, input outs_t o);
        q_steps.push_back('{rdy: rdy, z: z, st: st, o: o});
    endtask

    // A request that completes after `wait_n` stalled cycles.
    task automatic push_req(input logic [3:0] st, input int wait_n, input outs_t o, input outs_t o_done);
        for (int i = 0; i < wait_n; i++) push(st, 1'b0, logic'($urandom_range(0, 1)), o);
        push(st, 1'b1, logic'($urandom_range(0, 1)), o_done);
    endtask

    task automatic push_simple(input logic [3:0] st, input outs_t o);
        push(st, idle_rdy(), logic'($urandom_range(0, 1)), o);
    endtask

    // Expected per-cycle trace of one instruction, built from its class.
    task automatic build(input int kind, input int fwait, input int mwait, input logic zbr);
        outs_t o, o2;
        logic  taken;
        funct7b5_i = logic'($urandom_range(0, 1));
        funct3_i   = 3'($urandom_range(0, 7));
        case (kind)
            K_R:    opcode_i = 7'b0110011;
            K_I:    opcode_i = 7'b0010011;
            K_LUI:  opcode_i = 7'b0110111;
            K_LW:   opcode_i = 7'b0000011;
            K_SW:   opcode_i = 7'b0100011;
            K_BEQ:  begin opcode_i = 7'b1100011; funct3_i = 3'b000; end
            K_BNE:  begin opcode_i = 7'b1100011; funct3_i = 3'b001; end
            K_JAL:  opcode_i = 7'b1101111;
            K_JALR: opcode_i = 7'b1100111;
            K_BADBR: begin opcode_i = 7'b1100011; funct3_i = 3'($urandom_range(2, 7)); end
            default: opcode_i = 7'h7F;
        endcase

        o = '0; o.req = 1'b1; o.b = 2'b10; o.res = 2'b10;
        o2 = o; o2.irw = 1'b1; o2.pcw = 1'b1;
        push_req(ST_FETCH, fwait, o, o2);

        o = '0; o.a = 2'b01; o.b = 2'b01; o.imm = 3'b010;
        push_simple(ST_DECODE, o);

        case (kind)
            K_R: begin
                o = '0; o.a = 2'b10; o.op = 2'b10; push_simple(ST_EXECR, o);
            end
            K_I: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; push_simple(ST_EXECI, o);
            end
            K_LUI: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.imm = 3'b100; push_simple(ST_LUI, o);
            end
            K_LW: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; push_simple(ST_MEMADR, o);
                o = '0; o.req = 1'b1; o.adr = 1'b1; push_req(ST_MEMREAD, mwait, o, o);
                o = '0; o.res = 2'b01; o.rw = 1'b1; push_simple(ST_MEMWB, o);
            end
            K_SW: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.imm = 3'b001; push_simple(ST_MEMADR, o);
                o = '0; o.req = 1'b1; o.we = 1'b1; o.adr = 1'b1; push_req(ST_MEMWRITE, mwait, o, o);
            end
            K_BEQ, K_BNE, K_BADBR: begin
                taken = (kind == K_BEQ) ? zbr : (kind == K_BNE) ? ~zbr : 1'b0;
                o = '0; o.a = 2'b10; o.op = 2'b01; o.pcw = taken;
                push(ST_BRANCH, idle_rdy(), zbr, o);
            end
            K_JAL: begin
                o = '0; o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; push_simple(ST_JAL, o);
            end
            K_JALR: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; push_simple(ST_JALR, o);
                o = '0; o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1; push_simple(ST_JALR2, o);
            end
            default: ;
        endcase

        if (kind == K_BADBR || kind == K_ILL) begin
            o = '0; o.trap = 1'b1;
            for (int i = 0; i < 4; i++) push_simple(ST_TRAP, o);
        end else if (kind inside {K_R, K_I, K_LUI, K_JAL, K_JALR}) begin
            o = '0; o.rw = 1'b1; push_simple(ST_ALUWB, o);
        end
    endtask

    // Inputs change #1 after posedge; outputs are sampled on the negedge.
    task automatic run(input string name);
        int idx = 0;
        while (q_steps.size() > 0) begin
            step_t s = q_steps.pop_front();
            mem_ready_i = s.rdy;
            zero_i      = s.z;
            @(negedge clk_i);
            check($sformatf("%s[%0d].state", name, idx), 32'(state_o), 32'(s.st));
            check($sformatf("%s[%0d].outs", name, idx), 32'(observed()), 32'(s.o));
            @(posedge clk_i);
            #1;
            idx++;
        end
    endtask

    task automatic do_reset(input string name);
        rstn_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        check({name, ".state"}, 32'(state_o), 32'(ST_FETCH));
        check({name, ".req"}, 32'(mem_req_o), 32'd1);
        check({name, ".trap"}, 32'(trap_o), 32'd0);
        check({name, ".pcw"}, 32'(pc_write_o), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i = 1'b0; zero_i = 1'b0; mem_ready_i = 1'b0;
        opcode_i = 7'h0; funct3_i = 3'h0; funct7b5_i = 1'b0;
        idle_mode = 1;
        repeat (2) @(posedge clk_i);
        #1;
        do_reset("reset");

        // Directed: add, ready every cycle.
        build(K_R, 0, 0, 1'b0); run("add");
        build(K_R, 3, 0, 1'b0); run("fetch_wait3");
        build(K_LW, 0, 2, 1'b0); run("lw_wait2");
        build(K_BEQ, 0, 0, 1'b1); run("beq_z1");
        build(K_BEQ, 0, 0, 1'b0); run("beq_z0");
        build(K_BNE, 0, 0, 1'b1); run("bne_z1");
        build(K_BNE, 0, 0, 1'b0); run("bne_z0");
        build(K_JALR, 0, 0, 1'b0); run("jalr");
        build(K_ILL, 0, 0, 1'b0); run("illegal");
        do_reset("trap_reset");

        // Reset abandons an outstanding data request.
        build(K_SW, 0, 5, 1'b0);
        for (int i = 0; i < 5; i++) void'(q_steps.pop_back());
        run("sw_abandon");
        do_reset("sw_abandon_reset");

        idle_mode = 2;
        for (int n = 0; n < 200; n++) begin
            build(int'($urandom_range(K_R, K_JALR)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), logic'($urandom_range(0, 1)));
            run($sformatf("rnd%0d", n));
        end

        build(K_BADBR, 1, 0, logic'($urandom_range(0, 1))); run("bad_funct3");
        do_reset("bad_funct3_reset");
        build(K_JAL, 2, 0, 1'b0); run("jal_after_trap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
